pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline control sequencer for the 5-stage core.
- Sources the stall/flush controls for the IF/ID and ID/EX pipeline registers, and the PC write enable.
- Arbitrates three hazard sources: branch redirect from EX, load-use dependency into ID, and instruction-memory fetch wait.
- Sits beside the IF and ID stages. The PC mux and the pipeline registers consume its outputs in the same cycle.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, performance counter width (used only with PIPE_CTRL_PERF_EN).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID
- id_uses_rs1  in  1  the ID instruction reads rs1
- id_uses_rs2  in  1  the ID instruction reads rs2
- ex_mem_read  in  1  the EX instruction is a load
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- imem_req  out  1  fetch request for the current PC
- imem_ready  in  1  fetch data valid this cycle
- pc_write  out  1  PC register load enable
- if_id_stall  out  1  IF/ID hold
- if_id_flush  out  1  IF/ID clear to zero (NOP)
- id_ex_flush  out  1  ID/EX clear (bubble)
- perf_stall_cycles  out  CNT_W  cycles with pc_write=0 outside reset
- perf_flush_events  out  CNT_W  taken-branch redirects

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- State register: RUN, IWAIT, IKILL. Outputs are combinational from state and inputs (Mealy); only state and counters are registered.
- While reset is high:
  - state = RUN.
  - imem_req=0, pc_write=0, if_id_stall=0, if_id_flush=1, id_ex_flush=1.
  - Counters = 0.
- load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- RUN state (imem_req=1); priority is first match:
  1. ex_branch_taken:
     - pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_stall=0.
     - If !imem_ready, go to IKILL, because the outstanding fetch is wrong-path.
     - Otherwise stay in RUN.
  2. load_use:
     - pc_write=0, if_id_stall=1, id_ex_flush=1.
     - Stay in RUN. This is exactly one bubble per dependency.
     - If !imem_ready in the same cycle, go to IWAIT.
  3. !imem_ready:
     - pc_write=0, if_id_stall=1, id_ex_flush=1.
     - Go to IWAIT.
  4. Otherwise: pc_write=1, all stall/flush=0.
- IWAIT state (imem_req=1):
  - Hold pc_write=0, if_id_stall=1, id_ex_flush=1.
  - On imem_ready: outputs as RUN case 4 (or case 2 if load_use), then go to RUN.
  - ex_branch_taken is not possible in IWAIT, since EX holds a bubble after the first wait cycle. If asserted, treat it as RUN case 1 and go to IKILL if !imem_ready.
- IKILL state (imem_req=1):
  - pc_write=0, if_id_flush=1, id_ex_flush=1.
  - On imem_ready: the returned data is discarded via if_id_flush=1, then go to RUN. The next cycle re-fetches from the target PC.
- Flush dominates stall: if_id_flush=1 forces if_id_stall=0.
- A reset mid-IWAIT or mid-IKILL returns to RUN immediately; no pending fetch is tracked across reset.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cycles increments each non-reset cycle with pc_write=0.
  - perf_flush_events increments each cycle ex_branch_taken is acted on.
  - Both are CNT_W wide and wrap modulo 2^CNT_W.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset: assert reset for 3 cycles, imem_ready=1 -> during reset if_id_flush=1, id_ex_flush=1, pc_write=0. Cycle after release: pc_write=1, all flush/stall=0, state RUN.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle -> pc_write=0, if_id_stall=1, id_ex_flush=1 for exactly 1 cycle. Same with ex_rd=0 -> no stall.
- Fetch wait: imem_ready=0 for 4 cycles then 1 -> pc_write=0 and if_id_stall=1 for 4 cycles, then pc_write=1; with PERF, perf_stall_cycles=4.
- Branch redirect: ex_branch_taken=1 with load_use also true, imem_ready=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_stall=0 (branch wins); perf_flush_events=1.
- Wrong-path kill: ex_branch_taken=1 with imem_ready=0, then imem_ready=0 for 2 more cycles, then 1 -> IKILL holds pc_write=0 and if_id_flush=1 through the ready cycle, back to RUN with pc_write=1 the cycle after.
- Async reset in IWAIT: imem_ready=0 for 2 cycles, assert reset mid-cycle -> outputs take reset values without waiting for a clk edge; after release, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: arbitrates branch redirect, load-use and fetch wait into PC/IF-ID/ID-EX controls.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   output logic                  imem_req,
   input  logic                  imem_ready,
   output logic                  pc_write,
   output logic                  if_id_stall,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic [CNT_W-1:0]      perf_stall_cycles,
   output logic [CNT_W-1:0]      perf_flush_events
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      IWAIT = 2'd1,
      IKILL = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   load_use;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // RUN and IWAIT share one decision tree: a waiting fetch looks like a fresh !imem_ready in RUN.
   always_comb begin
      state_next  = state;
      imem_req    = 1'b1;
      pc_write    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (reset) begin
         imem_req    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_next  = RUN;
      end else begin
         case (state)
            RUN, IWAIT: begin
               if (ex_branch_taken) begin
                  pc_write    = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  state_next  = imem_ready ? RUN : IKILL;
               end else if (!imem_ready) begin
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
                  state_next  = IWAIT;
               end else if (load_use) begin
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
                  state_next  = RUN;
               end else begin
                  pc_write    = 1'b1;
                  state_next  = RUN;
               end
            end
            IKILL: begin
               // The fetch in flight is wrong-path; its data is dropped by the flush when it arrives.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (imem_ready) begin
                  state_next = RUN;
               end
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic branch_act;

   assign branch_act = !reset && ex_branch_taken && (state != IKILL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cycles <= '0;
         perf_flush_events <= '0;
      end else begin
         if (!pc_write) begin
            perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
         end
         if (branch_act) begin
            perf_flush_events <= perf_flush_events + CNT_W'(1);
         end
      end
   end
`else
   assign perf_stall_cycles = '0;
   assign perf_flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of single-cycle vectors plus multi-cycle hazard sequences.
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        ex_branch_taken;
   logic        imem_req;
   logic        imem_ready;
   logic        pc_write;
   logic        if_id_stall;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_events;

   pipe_hazard_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .id_rs1            (id_rs1),
      .id_rs2            (id_rs2),
      .id_uses_rs1       (id_uses_rs1),
      .id_uses_rs2       (id_uses_rs2),
      .ex_mem_read       (ex_mem_read),
      .ex_rd             (ex_rd),
      .ex_branch_taken   (ex_branch_taken),
      .imem_req          (imem_req),
      .imem_ready        (imem_ready),
      .pc_write          (pc_write),
      .if_id_stall       (if_id_stall),
      .if_id_flush       (if_id_flush),
      .id_ex_flush       (id_ex_flush),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_events (perf_flush_events)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs packed as {imem_req, pc_write, if_id_stall, if_id_flush, id_ex_flush}.
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_STALL = 5'b10101;
   localparam logic [4:0] O_BR    = 5'b11011;
   localparam logic [4:0] O_KILL  = 5'b10011;
   localparam logic [4:0] O_RST   = 5'b00011;

   typedef struct {
      string      name;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       mr;
      logic [4:0] rd;
      logic       bt;
      logic       rdy;
      logic [4:0] exp;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int expStall = 0;
   int expFlush = 0;
   vec_t vecs[9];

   function automatic vec_t mkVec(string nm, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                  logic mr, logic [4:0] rd, logic bt, logic rdy, logic [4:0] exp);
      vec_t v;
      v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.mr = mr; v.rd = rd; v.bt = bt; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(vec_t v);
      id_rs1          = v.rs1;
      id_rs2          = v.rs2;
      id_uses_rs1     = v.u1;
      id_uses_rs2     = v.u2;
      ex_mem_read     = v.mr;
      ex_rd           = v.rd;
      ex_branch_taken = v.bt;
      imem_ready      = v.rdy;
   endtask

   task automatic checkNow(string name, logic [4:0] exp);
      logic [31:0] pStall;
      logic [31:0] pFlush;
`ifdef PIPE_CTRL_PERF_EN
      pStall = expStall;
      pFlush = expFlush;
`else
      pStall = '0;
      pFlush = '0;
`endif
      checkOutput({name, ".ctl"}, {27'd0, imem_req, pc_write, if_id_stall, if_id_flush, id_ex_flush},
                  {27'd0, exp});
      checkOutput({name, ".stallcnt"}, perf_stall_cycles, pStall);
      checkOutput({name, ".flushcnt"}, perf_flush_events, pFlush);
   endtask

   // Entered and left at posedge+1; outputs sampled at the negedge in between.
   task automatic stepCycle(vec_t v);
      applyStimulus(v);
      @(negedge clk);
      checkNow(v.name, v.exp);
      if (!reset) begin
         if (!v.exp[3]) expStall++;
         if (v.bt && v.exp[3]) expFlush++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = mkVec("idle",        5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, O_RUN);
      vecs[1] = mkVec("lu_rs1",      5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, O_STALL);
      vecs[2] = mkVec("lu_rd0",      5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 1, O_RUN);
      vecs[3] = mkVec("lu_rs2",      5'd3, 5'd7, 1, 1, 1, 5'd7, 0, 1, O_STALL);
      vecs[4] = mkVec("rs2_unused",  5'd3, 5'd7, 1, 0, 1, 5'd7, 0, 1, O_RUN);
      vecs[5] = mkVec("not_load",    5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 1, O_RUN);
      vecs[6] = mkVec("br_over_lu",  5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, O_BR);
      vecs[7] = mkVec("br_alone",    5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, O_BR);
      vecs[8] = mkVec("rs1_unused",  5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 1, O_RUN);

      reset = 1'b1;
      applyStimulus(vecs[0]);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) stepCycle(mkVec($sformatf("reset%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, O_RST));
      reset = 1'b0;
      stepCycle(mkVec("post_reset", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));

      for (int i = 0; i < 9; i++) stepCycle(vecs[i]);

      $display("[TB] load-use single bubble");
      stepCycle(mkVec("lu_once", 5'd5, 0, 1, 0, 1, 5'd5, 0, 1, O_STALL));
      stepCycle(mkVec("lu_after", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));
      stepCycle(mkVec("lu_nordy", 5'd5, 0, 1, 0, 1, 5'd5, 0, 0, O_STALL));
      stepCycle(mkVec("lu_nordy_rel", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));

      $display("[TB] fetch wait 4 cycles");
      for (int i = 0; i < 4; i++) stepCycle(mkVec($sformatf("iwait%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, O_STALL));
      stepCycle(mkVec("iwait_done", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));

      $display("[TB] wrong-path kill");
      stepCycle(mkVec("kill_br", 0, 0, 0, 0, 0, 0, 1, 0, O_BR));
      stepCycle(mkVec("kill_w0", 0, 0, 0, 0, 0, 0, 0, 0, O_KILL));
      stepCycle(mkVec("kill_w1", 0, 0, 0, 0, 0, 0, 0, 0, O_KILL));
      stepCycle(mkVec("kill_rdy", 0, 0, 0, 0, 0, 0, 0, 1, O_KILL));
      stepCycle(mkVec("kill_after", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));

      $display("[TB] async reset in IWAIT");
      stepCycle(mkVec("ar_w0", 0, 0, 0, 0, 0, 0, 0, 0, O_STALL));
      stepCycle(mkVec("ar_w1", 0, 0, 0, 0, 0, 0, 0, 0, O_STALL));
      #2;
      reset = 1'b1;
      expStall = 0;
      expFlush = 0;
      #1;
      checkNow("ar_iwait_async", O_RST);
      @(posedge clk);
      #1;
      reset = 1'b0;
      stepCycle(mkVec("ar_iwait_rel", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));

      $display("[TB] async reset in IKILL");
      stepCycle(mkVec("ar_kbr", 0, 0, 0, 0, 0, 0, 1, 0, O_BR));
      #2;
      reset = 1'b1;
      expStall = 0;
      expFlush = 0;
      #1;
      checkNow("ar_ikill_async", O_RST);
      @(posedge clk);
      #1;
      reset = 1'b0;
      stepCycle(mkVec("ar_ikill_rel", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));
      stepCycle(mkVec("final_lu", 5'd9, 5'd9, 0, 1, 1, 5'd9, 0, 1, O_STALL));
      stepCycle(mkVec("final_idle", 0, 0, 0, 0, 0, 0, 0, 1, O_RUN));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
